biquad8_coeff_loader: RTL and testbench
=======================================

Name: biquad8_coeff_loader

Overview:
- Wishbone initiator that drives the 7-bit coefficient target port of one biquad8 filter wrapper.
- Host software or a config ROM pushes (address, coefficient) pairs into an internal FIFO, then pulses start.
- The block replays the FIFO contents as single-beat Wishbone writes, waits for each CDC-delayed ack, and reports done or error.
- Sits between the register fabric and one biquad wrapper; one instance per filter.

Parameters:
- DEPTH, 32, FIFO entries; power of 2, range 4..256.
- TIMEOUT, 255, wb_clk_i cycles to wait for ack/err/rty before aborting one write.
- UPD_ADR, 7'h00, target address of the update register.

Ports:
- wb_clk_i  in  1  Wishbone/system clock.
- wb_rst_ni  in  1  Asynchronous, active-low reset.
- coeff_valid_i  in  1  Push strobe.
- coeff_ready_o  out  1  FIFO can accept (not full and not busy).
- coeff_adr_i  in  7  Target byte address; bits [1:0] ignored and driven 0.
- coeff_dat_i  in  18  Coefficient, zero-extended to 32 bits.
- start_i  in  1  Begin replay (single-cycle pulse).
- busy_o  out  1  Replay in progress.
- done_o  out  1  One-cycle pulse at end of replay (success or abort).
- err_o  out  1  Sticky error; cleared by the next accepted start.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  7  Write address.
- wb_dat_o  out  32  Write data.
- wb_sel_o  out  4  Byte selects; always 4'hF during a cycle.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  Target responses.

Behaviour:
- Reset values: all outputs 0, FIFO emptied, FSM in IDLE. Reset mid-transaction drops cyc/stb immediately because the reset is asynchronous.
- Push: accepted when coeff_valid_i && coeff_ready_o. coeff_ready_o = !full && !busy_o.
- Start:
  - Accepted only in IDLE. start_i while busy is ignored.
  - A push and a start in the same cycle: the push is included in the replay.
- FSM states: IDLE, ISSUE, WAIT, GAP, UPD_ISSUE, UPD_WAIT, FIN.
  - IDLE --start--> ISSUE if the FIFO is non-empty; otherwise go to UPD_ISSUE (macro on) or FIN (macro off).
  - ISSUE: pop the FIFO head into the output regs, assert cyc/stb/we, go to WAIT. Registered outputs, so the bus is driven one cycle after entering ISSUE.
  - WAIT: hold all bus signals stable. Count cycles from the first asserted cycle.
    - On ack: deassert cyc/stb next cycle, go to GAP.
    - On err, rty, or counter reaching TIMEOUT: deassert cyc/stb, set err_o, flush the FIFO, go to FIN. The update write is skipped.
  - GAP: exactly one idle bus cycle with cyc=0, so the target's pending flag clears. Then go to ISSUE if the FIFO is non-empty, otherwise to UPD_ISSUE (macro on) or FIN.
  - UPD_ISSUE / UPD_WAIT: same handshake as ISSUE/WAIT with adr=UPD_ADR and dat=32'h1. Errors are handled as in WAIT.
  - FIN: pulse done_o for one cycle, go to IDLE.
- busy_o = (state != IDLE).
- Simultaneous ack and err: err wins.
- Ack seen outside WAIT/UPD_WAIT is ignored.
- Data path: wb_dat_o = {14'b0, coeff}; wb_adr_o = {coeff_adr_i[6:2], 2'b00}.
- FIFO:
  - Full at DEPTH entries; further pushes are not possible since ready is low.
  - Pointers wrap modulo DEPTH; level_o distinguishes full from empty.
- Minimum per-write bus occupancy is 1 cycle plus the ack latency, followed by the 1-cycle gap.

Optional Feature:
- BIQUAD_LOADER_AUTO_UPDATE_EN
  - Defined: after the last FIFO entry, issue one write of 32'h1 to UPD_ADR so the new coefficients latch atomically. Replay of an empty FIFO issues only this write.
  - Undefined: UPD states are removed; the replay ends after the last entry, and the host issues the update itself.

Test Plan:
- Push 3 entries (04:0x1234, 08:0x3FFFF, 10:0x00055), start, target acks 6 cycles after stb:
  - 3 writes in FIFO order, each with sel=F and a cyc=0 gap between them.
  - Macro on: a 4th write of adr 00, dat 1.
  - done_o pulses once, err_o=0, level_o=0.
- Fill DEPTH=32 entries: coeff_ready_o falls after the 32nd push, level_o=32. Start replays all 32 with correct pointer wrap after a second fill.
- Target never acks: cyc held for exactly TIMEOUT cycles, then dropped. err_o=1, FIFO flushed, no update write, done_o pulses. The next start clears err_o.
- wb_err_i asserted together with wb_ack_i on the 2nd of 4 writes: abort after the 2nd write, err_o=1, remaining entries discarded.
- Start with an empty FIFO:
  - Macro on: a single write adr 00 dat 1.
  - Macro off: done_o pulses 2 cycles after start with no bus activity.
- Assert wb_rst_ni low during WAIT: cyc/stb/busy go 0 asynchronously, level_o=0. After release, start with an empty FIFO behaves as in the previous case.

Source files
------------

// File: rtl/biquad8_coeff_loader_if.sv
// Single-beat Wishbone write channel between the coefficient loader (master) and a biquad8 target (slave).
interface biquad8_coeff_loader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat, sel,
        input  ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat, sel,
        output ack, err, rty
    );
endinterface

// File: rtl/biquad8_coeff_loader.sv
// FIFO-fed Wishbone initiator that replays (address, coefficient) writes into one biquad8 wrapper.
// Optional: define BIQUAD_LOADER_AUTO_UPDATE_EN to append a write of 1 to UPD_ADR after each replay.
module biquad8_coeff_loader #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [6:0]  UPD_ADR = 7'h00
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     coeff_valid_i,
    output logic                     coeff_ready_o,
    input  logic [6:0]               coeff_adr_i,
    input  logic [17:0]              coeff_dat_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   level_o,
    biquad8_coeff_loader_if.master   wb
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(32'd0);
    localparam logic [LW-1:0] LVL_ONE  = LW'(32'd1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
`ifdef BIQUAD_LOADER_AUTO_UPDATE_EN
        S_UPD_ISSUE,
        S_UPD_WAIT,
`endif
        S_FIN
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   cnt_q;
    logic            cyc_q;
    logic            stb_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [6:0]      adr_q;
    logic [31:0]     dat_q;
    logic            done_q;
    logic            err_q;
    logic [24:0]     mem_q [DEPTH];

    logic            push_s;
    logic            full_s;
    logic            bus_abort_s;
    logic            bus_end_s;
    logic [24:0]     head_s;
    state_e          after_data_s;

    assign full_s        = (level_q == LVL_FULL);
    assign coeff_ready_o = !full_s && (state_q == S_IDLE);
    assign push_s        = coeff_valid_i && coeff_ready_o;
    assign head_s        = mem_q[rd_ptr_q];
    // Error and retry outrank a simultaneous ack; the last counted cycle aborts too.
    assign bus_abort_s   = wb.err || wb.rty || (cnt_q == CNT_LAST);
    assign bus_end_s     = bus_abort_s || wb.ack;
`ifdef BIQUAD_LOADER_AUTO_UPDATE_EN
    assign after_data_s  = S_UPD_ISSUE;
`else
    assign after_data_s  = S_FIN;
`endif

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign level_o = level_q;
    assign wb.cyc  = cyc_q;
    assign wb.stb  = stb_q;
    assign wb.we   = we_q;
    assign wb.sel  = sel_q;
    assign wb.adr  = adr_q;
    assign wb.dat  = dat_q;

    // FIFO storage; occupancy lives in level_q so the array needs no reset
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {coeff_adr_i & 7'b111_1100, coeff_dat_i};
        end
    end

    // Replay sequencer, FIFO pointers and all registered bus/status outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            level_q  <= LVL_ZERO;
            cnt_q    <= CNT_ZERO;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            adr_q    <= 7'h00;
            dat_q    <= 32'h0000_0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (push_s) begin
                        wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        level_q  <= level_q + LVL_ONE;
                    end
                    if (start_i) begin
                        err_q   <= 1'b0;
                        state_q <= (push_s || (level_q != LVL_ZERO)) ? S_ISSUE : after_data_s;
                    end
                end
                S_ISSUE: begin
                    adr_q    <= head_s[24:18];
                    dat_q    <= {14'h0000, head_s[17:0]};
                    cyc_q    <= 1'b1;
                    stb_q    <= 1'b1;
                    we_q     <= 1'b1;
                    sel_q    <= 4'hF;
                    cnt_q    <= CNT_ZERO;
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    level_q  <= level_q - LVL_ONE;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus_end_s) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'h0;
                        if (bus_abort_s) begin
                            err_q    <= 1'b1;
                            wr_ptr_q <= PTR_ZERO;
                            rd_ptr_q <= PTR_ZERO;
                            level_q  <= LVL_ZERO;
                            state_q  <= S_FIN;
                        end else begin
                            state_q  <= S_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_GAP: begin
                    state_q <= (level_q != LVL_ZERO) ? S_ISSUE : after_data_s;
                end
`ifdef BIQUAD_LOADER_AUTO_UPDATE_EN
                S_UPD_ISSUE: begin
                    adr_q   <= UPD_ADR;
                    dat_q   <= 32'h0000_0001;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= 1'b1;
                    sel_q   <= 4'hF;
                    cnt_q   <= CNT_ZERO;
                    state_q <= S_UPD_WAIT;
                end
                S_UPD_WAIT: begin
                    if (bus_end_s) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= 4'h0;
                        err_q   <= err_q | bus_abort_s;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`endif
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader: table-driven replay plus hand-written timeout/error/reset sequences.
module tb_biquad8_coeff_loader;

    localparam int          DEPTH   = 32;
    localparam int          TIMEOUT = 255;
    localparam logic [6:0]  UPD_ADR = 7'h00;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        coeff_valid_i;
    logic        coeff_ready_o;
    logic [6:0]  coeff_adr_i;
    logic [17:0] coeff_dat_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [5:0]  level_o;

    always #5 wb_clk_i = ~wb_clk_i;

    biquad8_coeff_loader_if wb_if ();

    biquad8_coeff_loader #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .UPD_ADR (UPD_ADR)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .coeff_valid_i (coeff_valid_i),
        .coeff_ready_o (coeff_ready_o),
        .coeff_adr_i   (coeff_adr_i),
        .coeff_dat_i   (coeff_dat_i),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .level_o       (level_o),
        .wb            (wb_if.master)
    );

    typedef struct {
        logic [6:0]  adr;
        logic [17:0] dat;
        logic [6:0]  exp_adr;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [5];

    int n_tests = 0;
    int n_fail  = 0;

    // target model controls and bus statistics
    int   resp_mode = 0;   // 0: ack, 1: never respond, 2: ack+err on write err_on
    int   ack_lat   = 6;
    int   err_on    = 0;
    int   stb_cnt   = 0;
    int   wr_idx    = 0;
    int   rises     = 0;
    int   cyc_run   = 0;
    int   last_run  = 0;
    int   idle_run  = 0;
    int   min_gap   = 1000;
    bit   seen_fall = 1'b0;
    logic prev_cyc  = 1'b0;
    int   done_cnt  = 0;
    int   done_base = 0;

    logic [6:0]  log_adr [$];
    logic [31:0] log_dat [$];
    logic [3:0]  log_sel [$];
    logic        log_we  [$];
    logic [6:0]  m_adr   [$];
    logic [31:0] m_dat   [$];

    // Wishbone target: responds and logs on the falling edge, away from the DUT's active edge
    always @(negedge wb_clk_i) begin
        if (done_o === 1'b1) done_cnt++;
        wb_if.ack = 1'b0;
        wb_if.err = 1'b0;
        wb_if.rty = 1'b0;
        if (wb_if.cyc === 1'b1) begin
            if (prev_cyc !== 1'b1) begin
                rises++;
                if (seen_fall && idle_run < min_gap) min_gap = idle_run;
                cyc_run = 0;
                stb_cnt = 0;
            end
            cyc_run++;
            stb_cnt++;
            if (resp_mode != 1 && wb_if.stb === 1'b1 && stb_cnt == ack_lat) begin
                wr_idx++;
                wb_if.ack = 1'b1;
                if (resp_mode == 2 && wr_idx == err_on) wb_if.err = 1'b1;
                log_adr.push_back(wb_if.adr);
                log_dat.push_back(wb_if.dat);
                log_sel.push_back(wb_if.sel);
                log_we.push_back(wb_if.we);
            end
        end else begin
            if (prev_cyc === 1'b1) begin
                last_run  = cyc_run;
                seen_fall = 1'b1;
                idle_run  = 0;
            end
            idle_run++;
            stb_cnt = 0;
        end
        prev_cyc = wb_if.cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        log_adr.delete(); log_dat.delete(); log_sel.delete(); log_we.delete();
        m_adr.delete(); m_dat.delete();
        rises = 0; wr_idx = 0; min_gap = 1000; seen_fall = 1'b0;
        done_base = done_cnt;
    endtask

    task automatic expect_update();
`ifdef BIQUAD_LOADER_AUTO_UPDATE_EN
        m_adr.push_back(UPD_ADR);
        m_dat.push_back(32'h0000_0001);
`endif
    endtask

    task automatic push(input logic [6:0] a, input logic [17:0] d);
        coeff_valid_i = 1'b1;
        coeff_adr_i   = a;
        coeff_dat_i   = d;
        @(negedge wb_clk_i);
        coeff_valid_i = 1'b0;
    endtask

    task automatic push_model(input logic [6:0] a, input logic [17:0] d);
        m_adr.push_back({a[6:2], 2'b00});
        m_dat.push_back({14'h0000, d});
        push(a, d);
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        while (done_o !== 1'b1 && lat < budget) begin
            @(negedge wb_clk_i);
            lat++;
        end
        check({tag, "_done_seen"}, {31'h0, done_o}, 32'h1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_wr_count"}, log_adr.size(), m_adr.size());
        for (int i = 0; i < m_adr.size() && i < log_adr.size(); i++) begin
            check($sformatf("%s_adr%0d", tag, i), {25'h0, log_adr[i]}, {25'h0, m_adr[i]});
            check($sformatf("%s_dat%0d", tag, i), log_dat[i], m_dat[i]);
            check($sformatf("%s_sel%0d", tag, i), {28'h0, log_sel[i]}, 32'hF);
            check($sformatf("%s_we%0d", tag, i), {31'h0, log_we[i]}, 32'h1);
        end
    endtask

    task automatic finish_checks(input string tag, input logic exp_err);
        repeat (3) @(negedge wb_clk_i);
        check({tag, "_done_once"}, done_cnt - done_base, 1);
        check({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
        check({tag, "_level"}, {26'h0, level_o}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    endtask

    task automatic run_empty_start(input string tag);
        int lat;
        clear_stats();
        expect_update();
        start_pulse();
        wait_done(tag, 100, lat);
`ifndef BIQUAD_LOADER_AUTO_UPDATE_EN
        check({tag, "_latency"}, lat + 1, 2);
`endif
        finish_checks(tag, 1'b0);
        compare_log(tag);
    endtask

    task automatic fill_and_replay(input string tag, input int seed);
        int lat;
        clear_stats();
        for (int i = 0; i < DEPTH; i++) begin
            push_model(7'(i * 4 + (i & 3)), 18'(i * 4099 + seed));
        end
        check({tag, "_full_level"}, {26'h0, level_o}, DEPTH);
        check({tag, "_full_ready"}, {31'h0, coeff_ready_o}, 32'h0);
        push(7'h5C, 18'h1FFFF);
        check({tag, "_overflow_level"}, {26'h0, level_o}, DEPTH);
        expect_update();
        start_pulse();
        wait_done(tag, 3000, lat);
        finish_checks(tag, 1'b0);
        compare_log(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs[0] = '{7'h04, 18'h01234, 7'h04, 32'h0000_1234};
        vecs[1] = '{7'h08, 18'h3FFFF, 7'h08, 32'h0003_FFFF};
        vecs[2] = '{7'h10, 18'h00055, 7'h10, 32'h0000_0055};
        vecs[3] = '{7'h0B, 18'h2AAAA, 7'h08, 32'h0002_AAAA};
        vecs[4] = '{7'h7F, 18'h00001, 7'h7C, 32'h0000_0001};

        wb_rst_ni = 1'b0; coeff_valid_i = 1'b0; coeff_adr_i = 7'h00;
        coeff_dat_i = 18'h00000; start_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_cyc",   {31'h0, wb_if.cyc}, 32'h0);
        check("rst_stb",   {31'h0, wb_if.stb}, 32'h0);
        check("rst_we",    {31'h0, wb_if.we},  32'h0);
        check("rst_sel",   {28'h0, wb_if.sel}, 32'h0);
        check("rst_adr",   {25'h0, wb_if.adr}, 32'h0);
        check("rst_dat",   wb_if.dat, 32'h0);
        check("rst_busy",  {31'h0, busy_o},  32'h0);
        check("rst_done",  {31'h0, done_o},  32'h0);
        check("rst_err",   {31'h0, err_o},   32'h0);
        check("rst_level", {26'h0, level_o}, 32'h0);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);

        // table replay, ack 6 cycles into each strobe, a stray start mid-replay
        clear_stats();
        resp_mode = 0; ack_lat = 6;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].adr, vecs[i].dat);
            m_adr.push_back(vecs[i].exp_adr);
            m_dat.push_back(vecs[i].exp_dat);
        end
        expect_update();
        check("tbl_level", {26'h0, level_o}, 32'h5);
        start_pulse();
        repeat (10) @(negedge wb_clk_i);
        start_pulse();
        wait_done("tbl", 500, lat);
        finish_checks("tbl", 1'b0);
        compare_log("tbl");
        check("tbl_gap", {31'h0, (min_gap >= 1)}, 32'h1);
        check("tbl_ready", {31'h0, coeff_ready_o}, 32'h1);

        // two full fills, the first starting mid-array so pointers wrap
        ack_lat = 1;
        fill_and_replay("fill1", 3);
        fill_and_replay("fill2", 77);

        // target never answers
        clear_stats();
        resp_mode = 1;
        push(7'h04, 18'h00011);
        push(7'h08, 18'h00022);
        start_pulse();
        wait_done("tmo", 1000, lat);
        finish_checks("tmo", 1'b1);
        check("tmo_cyc_len", last_run, TIMEOUT);
        check("tmo_writes", rises, 1);
        check("tmo_logged", log_adr.size(), 0);
        resp_mode = 0;
        run_empty_start("tmo_clear");

        // ack+err on the 2nd of 4 writes
        clear_stats();
        resp_mode = 2; err_on = 2; ack_lat = 3;
        push_model(7'h14, 18'h00101);
        push_model(7'h18, 18'h00202);
        push(7'h1C, 18'h00303);
        push(7'h20, 18'h00404);
        start_pulse();
        wait_done("errw", 500, lat);
        finish_checks("errw", 1'b1);
        compare_log("errw");
        check("errw_writes", rises, 2);
        resp_mode = 0;

        // empty FIFO start
        run_empty_start("empty");

        // push and start in the same cycle
        clear_stats();
        coeff_valid_i = 1'b1; coeff_adr_i = 7'h26; coeff_dat_i = 18'h0ABCD; start_i = 1'b1;
        m_adr.push_back(7'h24); m_dat.push_back(32'h0000_ABCD);
        expect_update();
        @(negedge wb_clk_i);
        coeff_valid_i = 1'b0; start_i = 1'b0;
        wait_done("same", 200, lat);
        finish_checks("same", 1'b0);
        compare_log("same");

        // asynchronous reset while a write is waiting
        clear_stats();
        resp_mode = 1;
        push(7'h30, 18'h00aaa);
        push(7'h34, 18'h00bbb);
        start_pulse();
        lat = 0;
        while (wb_if.cyc !== 1'b1 && lat < 20) begin
            @(negedge wb_clk_i);
            lat++;
        end
        check("rstw_cyc_up", {31'h0, wb_if.cyc}, 32'h1);
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_ni = 1'b0;
        #1;
        check("rstw_cyc",   {31'h0, wb_if.cyc}, 32'h0);
        check("rstw_stb",   {31'h0, wb_if.stb}, 32'h0);
        check("rstw_busy",  {31'h0, busy_o},    32'h0);
        check("rstw_level", {26'h0, level_o},   32'h0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        resp_mode = 0;
        @(negedge wb_clk_i);
        run_empty_start("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
